// File: rtl/color_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | color_pkg : ASCII codes, preset colours, parser state and helpers     |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
package color_pkg;

  localparam logic [7:0] c_ascii_hash = 8'h23;
  localparam logic [7:0] c_ascii_0    = 8'h30;
  localparam logic [7:0] c_ascii_9    = 8'h39;
  localparam logic [7:0] c_ascii_a_uc = 8'h41;
  localparam logic [7:0] c_ascii_z_uc = 8'h5A;
  localparam logic [7:0] c_ascii_a_lc = 8'h61;
  localparam logic [7:0] c_ascii_f_lc = 8'h66;

  localparam logic [23:0] c_rgb_red     = 24'hFF0000;
  localparam logic [23:0] c_rgb_green   = 24'h00FF00;
  localparam logic [23:0] c_rgb_blue    = 24'h0000FF;
  localparam logic [23:0] c_rgb_white   = 24'hFFFFFF;
  localparam logic [23:0] c_rgb_black   = 24'h000000;
  localparam logic [23:0] c_rgb_yellow  = 24'hFFFF00;
  localparam logic [23:0] c_rgb_purple  = 24'hFF00FF;
  localparam logic [23:0] c_rgb_cyan    = 24'h00FFFF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HEX  = 1'b1
  } state_t;

  // Result is right-aligned; callers keep the low `width` bits.
  function automatic logic [23:0] rgb888_to_color(input logic [23:0] value, input int width);
    if (width == 16) return {8'h00, value[23:19], value[15:10], value[7:3]};
    return value;
  endfunction

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ascii_hex_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ascii_hex_decode : classifies one ASCII byte (hex, decimal, preset)   |
// | Revision         : 1.0                                                |
// +----------------------------------------------------------------------+
module ascii_hex_decode
  import color_pkg::*;
(
  input  logic [7:0]  byte_in,
  output logic        is_hex,
  output logic [3:0]  nibble,
  output logic        is_dec,
  output logic [3:0]  dec,
  output logic        preset_hit,
  output logic [23:0] preset_rgb
);

  logic [7:0] w_lc;
  logic       w_is_af;

  always_comb begin
    w_lc = byte_in;
    if ((byte_in >= c_ascii_a_uc) && (byte_in <= c_ascii_z_uc)) w_lc = byte_in | 8'h20;

    is_dec  = (byte_in >= c_ascii_0) && (byte_in <= c_ascii_9);
    dec     = byte_in[3:0];
    w_is_af = (w_lc >= c_ascii_a_lc) && (w_lc <= c_ascii_f_lc);
    is_hex  = is_dec | w_is_af;
    // 'a'..'f' have low nibble 1..6, so +9 maps them onto 10..15
    nibble  = is_dec ? byte_in[3:0] : (w_lc[3:0] + 4'd9);

    preset_hit = 1'b1;
    case (w_lc)
      8'h72:   preset_rgb = c_rgb_red;
      8'h67:   preset_rgb = c_rgb_green;
      8'h62:   preset_rgb = c_rgb_blue;
      8'h77:   preset_rgb = c_rgb_white;
      8'h6B:   preset_rgb = c_rgb_black;
      8'h79:   preset_rgb = c_rgb_yellow;
      8'h70:   preset_rgb = c_rgb_purple;
      8'h63:   preset_rgb = c_rgb_cyan;
      default: begin
        preset_hit = 1'b0;
        preset_rgb = 24'h000000;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/color_cmd_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | color_cmd_parser : UART byte parser driving per-channel colour regs   |
// | Revision         : 1.0                                                |
// +----------------------------------------------------------------------+
module color_cmd_parser
  import color_pkg::*;
#(
  parameter int          NUM_CH        = 4,
  parameter int          COLOR_W       = 16,
  parameter int          TIMEOUT_CYC   = 27000000,
  parameter logic [23:0] DEFAULT_COLOR = 24'hFF0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        byte_valid,
  input  logic [7:0]                  byte_data,
  output logic [NUM_CH*COLOR_W-1:0]   colors,
  output logic [ch_width(NUM_CH)-1:0] sel_ch,
  output logic                        upd_valid,
  output logic [ch_width(NUM_CH)-1:0] upd_ch,
  output logic                        cmd_err,
  output logic                        busy
);

  localparam int                 c_ch_w         = ch_width(NUM_CH);
  localparam logic [4:0]         c_num_ch       = 5'(NUM_CH);
  localparam logic [23:0]        c_default_full = rgb888_to_color(DEFAULT_COLOR, COLOR_W);
  localparam logic [COLOR_W-1:0] c_default      = c_default_full[COLOR_W-1:0];

  state_t       r_state, w_state_nxt;
  logic [2:0]   r_cnt;
  logic [19:0]  r_shift;        // first five nibbles; the sixth joins combinationally
  logic [COLOR_W-1:0] r_colors [NUM_CH];

  logic         w_is_hex, w_is_dec, w_preset_hit;
  logic [3:0]   w_nibble, w_dec;
  logic [23:0]  w_preset_rgb, w_wr_rgb, w_wr_full;
  logic         w_wr_en, w_sel_ld, w_err, w_shift, w_cnt_clr, w_tmo_hit;

  ascii_hex_decode u_dec (
    .byte_in    (byte_data),
    .is_hex     (w_is_hex),
    .nibble     (w_nibble),
    .is_dec     (w_is_dec),
    .dec        (w_dec),
    .preset_hit (w_preset_hit),
    .preset_rgb (w_preset_rgb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_wr_rgb    = w_preset_rgb;
    w_sel_ld    = 1'b0;
    w_err       = 1'b0;
    w_shift     = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (byte_valid) begin
          if (w_preset_hit) begin
            w_wr_en = 1'b1;
          end else if (w_is_dec && ({1'b0, w_dec} < c_num_ch)) begin
            w_sel_ld = 1'b1;
          end else if (byte_data == c_ascii_hash) begin
            w_state_nxt = ST_HEX;
            w_cnt_clr   = 1'b1;
          end
        end
      end
      ST_HEX: begin
        if (byte_valid) begin
          if (w_is_hex) begin
            w_shift = 1'b1;
            if (r_cnt == 3'd5) begin
              w_wr_en     = 1'b1;
              w_wr_rgb    = {r_shift, w_nibble};
              w_state_nxt = ST_IDLE;
            end
          end else if (byte_data == c_ascii_hash) begin
            w_err     = 1'b1;
            w_cnt_clr = 1'b1;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else if (w_tmo_hit) begin
          w_err       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy      = (r_state == ST_HEX);
  assign w_wr_full = rgb888_to_color(w_wr_rgb, COLOR_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_ch    <= '0;
      upd_valid <= 1'b0;
      upd_ch    <= '0;
      cmd_err   <= 1'b0;
      r_cnt     <= 3'd0;
      r_shift   <= 20'h0;
    end else begin
      upd_valid <= w_wr_en;
      cmd_err   <= w_err;
      if (w_wr_en)  upd_ch <= sel_ch;
      if (w_sel_ld) sel_ch <= c_ch_w'(w_dec);
      if (w_cnt_clr) begin
        r_cnt <= 3'd0;
      end else if (w_shift) begin
        r_cnt   <= r_cnt + 3'd1;
        r_shift <= {r_shift[15:0], w_nibble};
      end
    end
  end

  generate
    if (TIMEOUT_CYC > 0) begin : g_tmo
      localparam int c_tmo_w = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
      logic [c_tmo_w-1:0] r_tmo;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         r_tmo <= '0;
        else if (!busy || byte_valid)       r_tmo <= '0;
        else                                r_tmo <= r_tmo + 1'b1;
      end
      assign w_tmo_hit = busy && (r_tmo == c_tmo_w'(TIMEOUT_CYC - 1));
    end else begin : g_no_tmo
      assign w_tmo_hit = 1'b0;
    end
  endgenerate

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   r_colors[i] <= c_default;
        else if (w_wr_en && (sel_ch == c_ch_w'(i)))   r_colors[i] <= w_wr_full[COLOR_W-1:0];
      end
      assign colors[i*COLOR_W +: COLOR_W] = r_colors[i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_color_cmd_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_color_cmd_parser : RGB565 and RGB888 parsers vs a command model    |
// | Revision            : 1.0                                             |
// +----------------------------------------------------------------------+
module tb_color_cmd_parser;

  localparam int NCH = 4;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        byte_valid;
  logic [7:0]  byte_data;

  logic [63:0] colors16;
  logic [95:0] colors24;
  logic [1:0]  sel16, sel24, updch16, updch24;
  logic        upd16, upd24, err16, err24, busy16, busy24;

  int n_checks = 0;
  int n_errors = 0;

  color_cmd_parser #(.NUM_CH(NCH), .COLOR_W(16), .TIMEOUT_CYC(TMO), .DEFAULT_COLOR(24'hFF0000)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .colors(colors16), .sel_ch(sel16), .upd_valid(upd16), .upd_ch(updch16),
    .cmd_err(err16), .busy(busy16)
  );

  color_cmd_parser #(.NUM_CH(NCH), .COLOR_W(24), .TIMEOUT_CYC(TMO), .DEFAULT_COLOR(24'hFF0000)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .colors(colors24), .sel_ch(sel24), .upd_valid(upd24), .upd_ch(updch24),
    .cmd_err(err24), .busy(busy24)
  );

  always #5 clk = ~clk;

  // Reference model: command-level view of the byte stream
  logic [23:0] m_col [NCH];
  int          m_sel, m_n, m_idle, m_updch;
  bit          m_hex, m_upd, m_err;
  logic [23:0] m_acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to565(input logic [23:0] rgb);
    return {rgb[23:19], rgb[15:10], rgb[7:3]};
  endfunction

  function automatic logic [24:0] preset_of(input logic [7:0] ch);
    logic [7:0] lc;
    lc = (ch >= "A" && ch <= "Z") ? ch + 8'd32 : ch;
    case (lc)
      "r": return {1'b1, 24'hFF0000};
      "g": return {1'b1, 24'h00FF00};
      "b": return {1'b1, 24'h0000FF};
      "w": return {1'b1, 24'hFFFFFF};
      "k": return {1'b1, 24'h000000};
      "y": return {1'b1, 24'hFFFF00};
      "p": return {1'b1, 24'hFF00FF};
      "c": return {1'b1, 24'h00FFFF};
      default: return 25'h0;
    endcase
  endfunction

  function automatic int hex_val(input logic [7:0] ch);
    if (ch >= "0" && ch <= "9") return int'(ch) - 48;
    if (ch >= "a" && ch <= "f") return int'(ch) - 87;
    if (ch >= "A" && ch <= "F") return int'(ch) - 55;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_col[i] = 24'hFF0000;
    m_sel = 0; m_n = 0; m_idle = 0; m_updch = 0;
    m_hex = 0; m_upd = 0; m_err = 0; m_acc = 24'h0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] b);
    logic [24:0] p;
    int          h;
    m_upd = 0;
    m_err = 0;
    p = preset_of(b);
    h = hex_val(b);
    if (!m_hex) begin
      if (v) begin
        if (p[24]) begin
          m_col[m_sel] = p[23:0]; m_upd = 1; m_updch = m_sel;
        end else if (b >= "0" && b <= "9" && (int'(b) - 48) < NCH) begin
          m_sel = int'(b) - 48;
        end else if (b == "#") begin
          m_hex = 1; m_n = 0; m_idle = 0;
        end
      end
    end else if (v) begin
      m_idle = 0;
      if (h >= 0) begin
        m_acc = (m_acc << 4) | 24'(h);
        m_n++;
        if (m_n == 6) begin
          m_col[m_sel] = m_acc; m_upd = 1; m_updch = m_sel; m_hex = 0;
        end
      end else if (b == "#") begin
        m_n = 0; m_err = 1;
      end else begin
        m_hex = 0; m_err = 1;
      end
    end else begin
      m_idle++;
      if (m_idle == TMO) begin
        m_hex = 0; m_err = 1;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("col16[%0d]", i), colors16[i*16 +: 16], to565(m_col[i]));
      check($sformatf("col24[%0d]", i), colors24[i*24 +: 24], m_col[i]);
    end
    check("sel16", sel16, m_sel);
    check("sel24", sel24, m_sel);
    check("upd16", upd16, m_upd);
    check("upd24", upd24, m_upd);
    check("err16", err16, m_err);
    check("err24", err24, m_err);
    check("busy16", busy16, m_hex);
    check("busy24", busy24, m_hex);
    if (m_upd) begin
      check("updch16", updch16, m_updch);
      check("updch24", updch24, m_updch);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] b);
    byte_valid = v;
    byte_data  = b;
    @(posedge clk);
    model_step(v, b);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    check_all();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    check("rst_col16", colors16, 64'hF800_F800_F800_F800);
    check("rst_col24_lo", colors24[47:0], 48'hFF0000_FF0000);
    check("rst_sel", sel16, 0);
    check("rst_strobes", {upd16, err16, busy16, upd24, err24, busy24}, 6'b0);
    check("rst_updch", updch16, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    string alpha;
    alpha = "rgbwkypcRGBWKYPC0123456789#####abcdefABCDEF0123x!z ";
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    @(negedge clk);
    reset_dut();
    idle(2);

    send_str("2G");
    check("ch2_green", colors16[47:32], 16'h07E0);
    check("ch0_hold", colors16[15:0], 16'hF800);

    send_str("0#12AbEF");
    check("hex24", colors24[23:0], 24'h12ABEF);
    check("hex16", colors16[15:0], 16'h155D);
    idle(1);

    send_str("#12x");
    check("abort_err", err16, 1'b1);
    check("abort_busy", busy16, 1'b0);
    check("abort_col", colors16[15:0], 16'h155D);
    idle(1);
    check("abort_pulse", err16, 1'b0);
    send_str("b");
    check("after_abort_b", colors16[15:0], 16'h001F);

    send_str("#AB");
    idle(TMO - 1);
    check("tmo_pre_err", err16, 1'b0);
    check("tmo_pre_busy", busy16, 1'b1);
    idle(1);
    check("tmo_err", err16, 1'b1);
    check("tmo_busy", busy16, 1'b0);
    idle(1);

    send_str("#AB");
    idle(TMO - 1);
    send_str("C");
    check("tmo_race_err", err16, 1'b0);
    check("tmo_race_busy", busy16, 1'b1);
    send_str("DEF");
    check("tmo_race_col", colors24[23:0], 24'hABCDEF);

    send_str("37");
    check("sel_ignore7", sel16, 2'd3);
    send_str("#12");
    reset_dut();

    for (int it = 0; it < 1500; it++) begin
      step(1'b1, alpha[$urandom_range(0, alpha.len() - 1)]);
      if ($urandom_range(0, 15) == 0) idle(TMO + 1);
      else                            idle($urandom_range(0, 3));
      if (it == 700) reset_dut();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/color_cmd_parser.md
Name: color_cmd_parser

Overview:
- Multi-channel successor to the single-register UART colour selector. Consumes received UART bytes, decodes letter presets, channel-select digits and "#RRGGBB" hex commands, and holds one colour register per display channel.
- Sits between the UART receiver (byte strobe and data) and the display pixel path. Emits an update strobe per committed colour and an error strobe for malformed or timed-out commands.

Parameters:
- NUM_CH, 4, number of colour channels (1..10; one select digit per channel).
- COLOR_W, 16, colour width: 16 = RGB565, 24 = RGB888. Any other value is illegal.
- TIMEOUT_CYC, 27000000, idle cycles allowed between hex digits before abort; 0 disables the timeout.
- DEFAULT_COLOR, 24'hFF0000, RGB888 reset colour for every channel.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- byte_valid  in  1  one-cycle strobe: byte_data holds a received byte.
- byte_data  in  8  received ASCII byte.
- colors  out  NUM_CH*COLOR_W  packed colour registers; channel i occupies [i*COLOR_W +: COLOR_W].
- sel_ch  out  CH_W  currently selected channel; CH_W = max(1, clog2(NUM_CH)).
- upd_valid  out  1  one-cycle strobe: a channel colour was just written.
- upd_ch  out  CH_W  channel written; valid while upd_valid is high.
- cmd_err  out  1  one-cycle strobe: a hex command was aborted.
- busy  out  1  high while the parser is inside a hex sequence.

Behaviour:
- Reset (async assert, sync release): every channel = DEFAULT_COLOR converted to COLOR_W; sel_ch=0; state IDLE; upd_valid=0, upd_ch=0, cmd_err=0, busy=0; hex shift register and timeout counter cleared.
- Conversion to COLOR_W=16: R[7:3], G[7:2], B[7:3]. COLOR_W=24 passes the value through unchanged.
- Preset table (RGB888), case-insensitive: r FF0000, g 00FF00, b 0000FF, w FFFFFF, k 000000, y FFFF00, p FF00FF, c 00FFFF.
- IDLE state, byte_valid=1:
  - Preset letter: write colors[sel_ch] at this edge. upd_valid=1 and upd_ch=sel_ch in the next cycle, so the new colour and the strobe are visible together. Latency is 1 cycle.
  - Digit '0'..'9' with value < NUM_CH: sel_ch <= value. No upd_valid. Digits >= NUM_CH are silently ignored.
  - '#': go to HEX, clear digit count, busy=1 from the next cycle.
  - Any other byte: ignored, no strobe.
- HEX state, byte_valid=1:
  - Hex digit (0-9, a-f, A-F): shift 4 bits into a 24-bit register, count++, clear the timeout counter.
  - On the 6th digit: write colors[sel_ch] with the converted value, pulse upd_valid next cycle, return to IDLE, busy=0.
  - Non-hex byte other than '#': abort to IDLE, cmd_err=1 next cycle, byte discarded (not reinterpreted), colour unchanged.
  - '#': restart the sequence (count=0, stay in HEX), cmd_err=1 next cycle.
- Timeout, TIMEOUT_CYC>0, HEX with no byte: the counter increments each cycle. When it reaches TIMEOUT_CYC-1: IDLE, cmd_err=1 next cycle, colour unchanged.
- byte_valid in the same cycle as timeout expiry: the byte takes priority and the counter clears.
- byte_valid while upd_valid or cmd_err is high is accepted normally; the parser applies no backpressure.
- sel_ch never changes while in HEX: digits are treated as hex data there.
- Only one channel is written per cycle; other channels hold.
- cmd_err and upd_valid are mutually exclusive in any cycle.
- Reset asserted mid-sequence discards the partial command with no strobes.

Decomposition:
- Package color_pkg holds:
  - ASCII constants.
  - Preset RGB888 constants.
  - State enum (IDLE, HEX).
  - Function rgb888_to_color(value, width).
  - CH_W derivation helper.
- Sub-module ascii_hex_decode (combinational): byte in -> is_hex, nibble[3:0], is_dec, dec[3:0], preset_hit, preset_rgb[23:0]. It is instantiated once.

Test Plan:
- Reset release with COLOR_W=16, NUM_CH=4 -> colors=64'hF800_F800_F800_F800, sel_ch=0, no strobes.
- Bytes '2' then 'G' -> sel_ch=2; channel 2 = 16'h07E0; upd_valid one cycle with upd_ch=2; other channels stay 16'hF800.
- With COLOR_W=24: "#12AbEF" to channel 0 -> channel 0 = 24'h12ABEF; upd_valid asserted exactly the cycle after the 'F' strobe. Repeat with COLOR_W=16 -> 16'h155D.
- "#12x" -> cmd_err single pulse after 'x'; busy low; colour unchanged. A following 'b' is then applied as preset 16'h001F.
- TIMEOUT_CYC=8: "#AB" then 8 idle cycles -> cmd_err at expiry, return to IDLE. A byte arriving on the expiry cycle instead continues the sequence with no error.
- Digit '7' with NUM_CH=4 -> ignored, sel_ch unchanged. Then assert rst_n low mid "#12" -> all outputs return to reset values immediately, no strobes.
